// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request, RF write-port and read-bypass signals
interface rf_wb_arbiter_if;
    logic        req0_valid;
    logic [4:0]  req0_wa;
    logic [31:0] req0_wd;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_wa;
    logic [31:0] req1_wd;
    logic        req1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  rf_ra0;
    logic [4:0]  rf_ra1;
    logic [31:0] rf_rd0;
    logic [31:0] rf_rd1;
    logic [31:0] fwd_rd0;
    logic [31:0] fwd_rd1;

    modport master (
        output req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
        output rf_ra0, rf_ra1, rf_rd0, rf_rd1,
        input  req0_ready, req1_ready, rf_we, rf_wa, rf_wd, fwd_rd0, fwd_rd1
    );

    modport slave (
        input  req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
        input  rf_ra0, rf_ra1, rf_rd0, rf_rd1,
        output req0_ready, req1_ready, rf_we, rf_wa, rf_wd, fwd_rd0, fwd_rd1
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between WB and mul/div/load, with commit-stage bypass
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    rf_wb_arbiter_if.slave bus
);
    logic [3:0]  starve_cnt;
    logic        cv;
    logic [4:0]  cwa;
    logic [31:0] cwd;
    logic        forced;
    logic        t0;
    logic        t1;

    // Requester 0 wins unless requester 1 has waited STARVE_LIMIT cycles; readies are
    // held at their reset-cycle values while rst is high
    assign forced = !rst && (starve_cnt == 4'(STARVE_LIMIT));
    assign bus.req0_ready = !forced;
    assign bus.req1_ready = forced || !bus.req0_valid;
    assign t0 = bus.req0_valid && bus.req0_ready;
    assign t1 = bus.req1_valid && bus.req1_ready;

    // rst also masks the write enable so a write caught in the commit stage never reaches the RF
    assign bus.rf_we = cv && (cwa != 5'd0) && !rst;
    assign bus.rf_wa = cwa;
    assign bus.rf_wd = cwd;

    // Bypass: the value in the commit stage is newer than the RF contents
    always_comb begin
        bus.fwd_rd0 = (bus.rf_we && (cwa == bus.rf_ra0)) ? cwd : bus.rf_rd0;
        bus.fwd_rd1 = (bus.rf_we && (cwa == bus.rf_ra1)) ? cwd : bus.rf_rd1;
    end

    // Starvation counter and one-cycle commit stage
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            cv         <= 1'b0;
            cwa        <= 5'd0;
            cwd        <= 32'd0;
        end else begin
            starve_cnt <= (!bus.req1_valid || t1) ? 4'd0 : starve_cnt + 4'd1;
            cv         <= t0 || t1;
            if (t0) begin
                cwa <= bus.req0_wa;
                cwd <= bus.req0_wd;
            end else if (t1) begin
                cwa <= bus.req1_wa;
                cwd <= bus.req1_wd;
            end
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: random and directed writeback traffic checked against an architectural register model
module tb_rf_wb_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    logic [31:0] arch [32];
    bit          pv = 1'b0;
    logic [4:0]  pwa = 5'd0;
    logic [31:0] pwd = 32'd0;
    int          refused = 0;
    bit          obs_g1;
    logic [9:0]  grant_seq;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive, check against the model, then advance the model to the next cycle
    task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] r0, input logic [4:0] r1);
        bit forced, g0, g1;
        bus.req0_valid = v0;
        bus.req0_wa    = a0;
        bus.req0_wd    = d0;
        bus.req1_valid = v1;
        bus.req1_wa    = a1;
        bus.req1_wd    = d1;
        bus.rf_ra0     = r0;
        bus.rf_ra1     = r1;
        bus.rf_rd0     = mem[r0];
        bus.rf_rd1     = mem[r1];
        #1;
        forced = !rst && (refused == LIMIT);
        g0 = v0 && !forced;
        g1 = v1 && (forced || !v0);
        chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, !forced});
        chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, forced || !v0});
        chk("rf_we", {31'd0, bus.rf_we}, {31'd0, pv && (pwa != 5'd0) && !rst});
        if (pv && !rst) begin
            chk("rf_wa", {27'd0, bus.rf_wa}, {27'd0, pwa});
            chk("rf_wd", bus.rf_wd, pwd);
        end
        chk("fwd_rd0", bus.fwd_rd0, rst ? mem[r0] : arch[r0]);
        chk("fwd_rd1", bus.fwd_rd1, rst ? mem[r1] : arch[r1]);
        obs_g1 = bus.req1_valid && bus.req1_ready;
        if (rst) begin
            arch = mem;
            pv = 1'b0;
            refused = 0;
        end else begin
            mem = arch;
            pv = g0 || g1;
            pwa = g0 ? a0 : (g1 ? a1 : pwa);
            pwd = g0 ? d0 : (g1 ? d1 : pwd);
            if (pv && pwa != 5'd0) arch[pwa] = pwd;
            refused = (v1 && !g1) ? refused + 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r0, r1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = 32'd0;
            arch[i] = 32'd0;
        end
        @(posedge clk);
        #1;
        step(1'b1, 5'd4, 32'h1111, 1'b1, 5'd6, 32'h2222, 5'd4, 5'd6);
        idle(5'd0, 5'd0);
        rst = 1'b0;
        idle(5'd0, 5'd0);
        chk("reset_rf_wa", {27'd0, bus.rf_wa}, 32'd0);
        chk("reset_rf_wd", bus.rf_wd, 32'd0);

        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        idle(5'd5, 5'd0);
        idle(5'd5, 5'd0);

        grant_seq = 10'd0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 5'(10 + i), 32'h100 + i, 1'b1, 5'(20 + i), 32'h200 + i, 5'(10 + i), 5'(20 + i));
            grant_seq[i] = obs_g1;
        end
        chk("grant_seq", {22'd0, grant_seq}, {22'd0, 10'b1000010000});
        idle(5'd0, 5'd0);

        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 5'd7, 5'd8);
        idle(5'd7, 5'd8);
        idle(5'd7, 5'd8);

        for (int i = 1; i <= 3; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'hC0DE0000 + i, 5'(i), 5'd0);
        idle(5'd1, 5'd2);
        idle(5'd3, 5'd0);

        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd11, 32'h3000 + i, 1'b1, 5'd12, 32'h4000 + i, 5'd11, 5'd12);
        step(1'b1, 5'd9, 32'h99999999, 1'b1, 5'd13, 32'h13, 5'd9, 5'd13);
        rst = 1'b1;
        idle(5'd9, 5'd13);
        rst = 1'b0;
        idle(5'd9, 5'd13);
        grant_seq = 10'd0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 5'd14, 32'h5000 + i, 1'b1, 5'd15, 32'h6000 + i, 5'd14, 5'd15);
            grant_seq[i] = obs_g1;
        end
        chk("grant_after_reset", {22'd0, grant_seq}, {22'd0, 10'b0000010000});

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        rst = 1'b0;
        idle(5'd0, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
